ingress_frame_arbiter: RTL and testbench
========================================

# ingress_frame_arbiter

Frame-granular round-robin arbiter that shares one 16-bit AXI-stream frame datapath (the frame receptor ingress) between NUM_PORTS requesting streams. A grant is held from the first beat to the tlast beat of a frame, so frames are never interleaved. An optional inter-frame gap follows each frame. An 8-bit Avalon-MM slave provides a port enable mask, the gap length, grant status and per-port frame counters.

## Interface
- NUM_PORTS, 4: number of ingress streams, 2..8.
- clk  in  1  clock; all logic on rising edge.
- reset  in  1  synchronous, active-high.
- chipselect, write, read  in  1 each  Avalon-MM slave strobes.
- address  in  8  register index.
- writedata  in  8  register write data.
- readdata  out  8  registered read data.
- in_tdata  in  16*NUM_PORTS  port i occupies bits [16i+15:16i].
- in_tvalid, in_tlast  in  NUM_PORTS  per-port valid / last beat.
- in_tready  out  NUM_PORTS  per-port ready.
- out_tdata  out  16  to the frame receptor ingress tdata.
- out_tvalid, out_tlast  out  1  to the frame receptor ingress.
- out_tready  in  1  from the frame receptor ingress tready.

## Operation
- Register map (byte address / mode):
  - 0 RW: enable mask, bits [NUM_PORTS-1:0]; upper bits read 0.
  - 1 RW: gap, idle cycles after each frame (0..255).
  - 2 R: status. Bit 7 = busy (state BUSY). Bits [6:5] = state (IDLE=0, BUSY=1, GAP=2). Bits [2:0] = current/last grant.
  - 3..3+NUM_PORTS-1 R: 8-bit count of completed frames for port (address-3). Wraps 255->0.
  - Writes to read-only or unmapped addresses are ignored. Reads of unmapped addresses return 0.
- The FSM has three states: IDLE, BUSY, GAP.
- IDLE:
  - Requesters are ports with in_tvalid[i]=1 and mask[i]=1.
  - If there is at least one requester, grant the first requester strictly after last_grant in ascending order with wrap-around. Register the grant and go to BUSY.
  - Otherwise stay in IDLE.
- BUSY:
  - out_tdata, out_tvalid and out_tlast are combinationally muxed from the granted port.
  - in_tready[grant] = out_tready. All other in_tready bits are 0.
  - A beat transfers when out_tvalid && out_tready.
  - On transfer of a beat with tlast: increment count[grant] and set last_grant=grant. Go to GAP with gap_cnt=gap if gap!=0, else go to IDLE.
- GAP: decrement gap_cnt each cycle; when gap_cnt==1, go to IDLE.
- Outside BUSY: out_tvalid=0, out_tlast=0, out_tdata=0, all in_tready=0.
- Clearing a mask bit while that port is granted does not abort the frame. The mask is applied only at the next arbitration.
- Writing gap during GAP does not alter the running gap_cnt. The new value applies from the next frame.
- A frame counter increment and a read of the same counter in the same cycle: the read returns the pre-increment value.
- Reset mid-frame: returns immediately to IDLE, dropping the grant. Upstream must restart its frame.

## Timing
- Reset values:
  - state = IDLE, last_grant = NUM_PORTS-1 (so port 0 wins first), mask = all ones, gap = 0.
  - Counters = 0, gap_cnt = 0, readdata = 0.
  - All stream outputs are 0.
- Arbitration latency: a request seen in IDLE at cycle C gives BUSY and valid outputs at C+1.
- The stream path adds no register: the mux is combinational, 0-cycle latency, and upstream backpressure passes straight through.
- tlast transferring at cycle T:
  - gap=0: IDLE at T+1; the next frame's first beat is offered no earlier than T+2.
  - gap=G: GAP during cycles T+1..T+G, IDLE at T+G+1, next beat no earlier than T+G+2.
- readdata:
  - Updated one cycle after chipselect && read.
  - Is 0 in any cycle following no read.
- Register writes take effect on the next cycle.

## Test plan
- Single port: mask=0x1, gap=0, port 0 sends a 10-beat frame with tlast on beat 10 -> all 10 beats appear unchanged on out_*, count[0]=1, state returns to IDLE the cycle after tlast.
- Round-robin: ports 0..3 all valid continuously with 3-beat frames -> grant order 0,1,2,3,0; each count=1 after 4 frames, with no beat interleaving.
- Gap: gap=5, two back-to-back frames on port 2 -> exactly 5 GAP cycles plus 1 IDLE cycle between the tlast beat and the next first beat, out_tvalid=0 throughout.
- Backpressure: out_tready toggles 1,0,1,0 during a frame -> in_tready follows out_tready for the granted port only, with no beat duplicated or lost.
- Mask change mid-frame: clear the granted port 1's bit during its frame -> the frame completes and count[1] increments; port 1 is not granted afterwards although still valid.
- Counter wrap and reset: 256 one-beat frames on port 3 -> count[3] reads 0. Reset asserted mid-frame -> status reads 0x03 (IDLE, last_grant=3), mask reads 0x0F.

Source files
------------

// File: rtl/ingress_frame_arbiter.sv
// Frame-granular round-robin arbiter sharing one 16-bit AXI-stream datapath between
// NUM_PORTS ingress streams, with inter-frame gap and an 8-bit Avalon-MM control slave.
module ingress_frame_arbiter #(
   parameter int unsigned NUM_PORTS = 4
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      chipselect,
   input  logic                      write,
   input  logic                      read,
   input  logic [7:0]                address,
   input  logic [7:0]                writedata,
   output logic [7:0]                readdata,
   input  logic [16*NUM_PORTS-1:0]   in_tdata,
   input  logic [NUM_PORTS-1:0]      in_tvalid,
   input  logic [NUM_PORTS-1:0]      in_tlast,
   output logic [NUM_PORTS-1:0]      in_tready,
   output logic [15:0]               out_tdata,
   output logic                      out_tvalid,
   output logic                      out_tlast,
   input  logic                      out_tready
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      GAP  = 2'd2
   } state_t;

   state_t               state;
   logic [2:0]           grant;
   logic [NUM_PORTS-1:0] mask;
   logic [7:0]           gap;
   logic [7:0]           gap_cnt;
   logic [7:0]           frame_cnt [NUM_PORTS];

   logic [NUM_PORTS-1:0] req;
   logic                 found;
   logic [2:0]           next_grant;
   int unsigned          arb_idx;
   logic                 xfer;
   logic [7:0]           rd_val;

   assign req  = in_tvalid & mask;
   assign xfer = out_tvalid && out_tready;

   // grant doubles as last_grant: it only changes on a new grant, and every frame
   // ends with tlast before arbitration can run again.
   always_comb begin
      found      = 1'b0;
      next_grant = grant;
      arb_idx    = 0;
      for (int unsigned k = 1; k <= NUM_PORTS; k++) begin
         arb_idx = int'(grant) + k;
         if (arb_idx >= NUM_PORTS)
            arb_idx = arb_idx - NUM_PORTS;
         for (int unsigned j = 0; j < NUM_PORTS; j++) begin
            if (!found && req[j] && (j == arb_idx)) begin
               found      = 1'b1;
               next_grant = 3'(j);
            end
         end
      end
   end

   always_comb begin
      out_tdata  = '0;
      out_tvalid = 1'b0;
      out_tlast  = 1'b0;
      in_tready  = '0;
      if (state == BUSY) begin
         for (int unsigned i = 0; i < NUM_PORTS; i++) begin
            if (grant == 3'(i)) begin
               out_tdata    = in_tdata[16*i +: 16];
               out_tvalid   = in_tvalid[i];
               out_tlast    = in_tlast[i];
               in_tready[i] = out_tready;
            end
         end
      end
   end

   always_comb begin
      rd_val = '0;
      if (address == 8'd0)
         rd_val = 8'(mask);
      else if (address == 8'd1)
         rd_val = gap;
      else if (address == 8'd2)
         rd_val = {state == BUSY, state, 2'b00, grant};
      else begin
         for (int unsigned j = 0; j < NUM_PORTS; j++) begin
            if (address == 8'(3 + j))
               rd_val = frame_cnt[j];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         grant    <= 3'(NUM_PORTS - 1);
         mask     <= '1;
         gap      <= '0;
         gap_cnt  <= '0;
         readdata <= '0;
         for (int unsigned j = 0; j < NUM_PORTS; j++)
            frame_cnt[j] <= '0;
      end else begin
         readdata <= (chipselect && read) ? rd_val : '0;
         if (chipselect && write) begin
            if (address == 8'd0)
               mask <= writedata[NUM_PORTS-1:0];
            else if (address == 8'd1)
               gap <= writedata;
         end
         case (state)
            IDLE: begin
               if (found) begin
                  grant <= next_grant;
                  state <= BUSY;
               end
            end
            BUSY: begin
               if (xfer && out_tlast) begin
                  for (int unsigned j = 0; j < NUM_PORTS; j++) begin
                     if (grant == 3'(j))
                        frame_cnt[j] <= frame_cnt[j] + 8'd1;
                  end
                  if (gap != 8'd0) begin
                     gap_cnt <= gap;
                     state   <= GAP;
                  end else begin
                     state <= IDLE;
                  end
               end
            end
            GAP: begin
               gap_cnt <= gap_cnt - 8'd1;
               if (gap_cnt == 8'd1)
                  state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ingress_frame_arbiter.sv
// Directed self-checking bench for ingress_frame_arbiter: per-port frame sources,
// a beat log, and register reads checked against hand-computed values.
module tb_ingress_frame_arbiter;

   localparam int unsigned NP = 4;

   logic                 clk = 1'b0;
   logic                 reset;
   logic                 chipselect, write, read;
   logic [7:0]           address, writedata, readdata;
   logic [16*NP-1:0]     in_tdata;
   logic [NP-1:0]        in_tvalid, in_tlast, in_tready;
   logic [15:0]          out_tdata;
   logic                 out_tvalid, out_tlast, out_tready;

   ingress_frame_arbiter #(.NUM_PORTS(NP)) dut (
      .clk        (clk),
      .reset      (reset),
      .chipselect (chipselect),
      .write      (write),
      .read       (read),
      .address    (address),
      .writedata  (writedata),
      .readdata   (readdata),
      .in_tdata   (in_tdata),
      .in_tvalid  (in_tvalid),
      .in_tlast   (in_tlast),
      .in_tready  (in_tready),
      .out_tdata  (out_tdata),
      .out_tvalid (out_tvalid),
      .out_tlast  (out_tlast),
      .out_tready (out_tready)
   );

   always #5 clk = ~clk;

   typedef struct {
      int unsigned port;
      logic [15:0] data;
      logic        last;
      int unsigned cyc;
   } beat_t;

   beat_t       log_q[$];
   int unsigned src_left [NP];
   int unsigned src_frames [NP];
   int unsigned src_len [NP];
   logic [15:0] src_data [NP];
   int unsigned cyc, valid_cycles, c0;
   int          exp_port;
   int unsigned n_tests, n_fail;
   int unsigned ord [5] = '{0, 1, 2, 3, 0};

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic drive_srcs();
      for (int p = 0; p < NP; p++) begin
         in_tvalid[p]       = (src_frames[p] != 0);
         in_tlast[p]        = (src_frames[p] != 0) && (src_left[p] == 1);
         in_tdata[16*p +: 16] = src_data[p];
      end
   endtask

   task automatic load(input int p, input int unsigned len, input int unsigned frames,
                       input logic [15:0] base);
      src_len[p]    = len;
      src_left[p]   = len;
      src_frames[p] = frames;
      src_data[p]   = base;
      drive_srcs();
   endtask

   task automatic clear_srcs();
      for (int p = 0; p < NP; p++) src_frames[p] = 0;
      drive_srcs();
   endtask

   // Sample the settled cycle, clock once, then advance the sources that transferred.
   task automatic step();
      int unsigned in_x;
      int          xp;
      logic        out_x;
      #1;
      in_x = 0;
      xp   = 0;
      for (int p = 0; p < NP; p++)
         if (in_tvalid[p] && in_tready[p]) begin
            in_x++;
            xp = p;
         end
      out_x = out_tvalid && out_tready;
      if (out_tvalid) valid_cycles++;
      if (in_x != 0 || out_x) check("xfer", in_x, {31'd0, out_x});
      if (in_x == 1) begin
         check("beat_data", out_tdata, src_data[xp]);
         check("beat_last", out_tlast, in_tlast[xp]);
         log_q.push_back('{port: xp, data: src_data[xp], last: in_tlast[xp], cyc: cyc});
      end
      if (exp_port >= 0 && out_tvalid)
         check("tready_fwd", in_tready, out_tready ? (32'd1 << exp_port) : 32'd0);
      @(posedge clk);
      #1;
      cyc++;
      if (in_x == 1) begin
         src_data[xp]++;
         if (src_left[xp] == 1) begin
            src_frames[xp]--;
            src_left[xp] = src_len[xp];
         end else begin
            src_left[xp]--;
         end
      end
      drive_srcs();
   endtask

   task automatic wait_beats(input int unsigned n, input int unsigned bound);
      int unsigned k = 0;
      while (log_q.size() < n && k < bound) begin
         step();
         k++;
      end
      if (log_q.size() < n) check("beat_timeout", log_q.size(), n);
   endtask

   task automatic reg_write(input logic [7:0] a, input logic [7:0] d);
      chipselect = 1'b1; write = 1'b1; address = a; writedata = d;
      step();
      chipselect = 1'b0; write = 1'b0;
   endtask

   task automatic rd_check(input string tag, input logic [7:0] a, input logic [7:0] exp);
      chipselect = 1'b1; read = 1'b1; address = a;
      step();
      chipselect = 1'b0; read = 1'b0;
      check(tag, readdata, exp);
   endtask

   task automatic do_reset(input int unsigned n);
      reset = 1'b1;
      clear_srcs();
      repeat (n) step();
      reset = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      n_tests = 0; n_fail = 0; cyc = 0; valid_cycles = 0; exp_port = -1;
      chipselect = 0; write = 0; read = 0; address = '0; writedata = '0;
      out_tready = 1'b1; in_tdata = '0; in_tvalid = '0; in_tlast = '0;
      for (int p = 0; p < NP; p++) begin
         src_left[p] = 0; src_frames[p] = 0; src_len[p] = 0; src_data[p] = '0;
      end

      // reset state
      do_reset(3);
      check("rst_tvalid", out_tvalid, 1'b0);
      check("rst_tready", in_tready, 4'h0);
      check("rst_rdata", readdata, 8'h00);
      rd_check("rst_mask", 8'd0, 8'h0F);
      rd_check("rst_gap", 8'd1, 8'h00);
      rd_check("rst_status", 8'd2, 8'h03);
      rd_check("rst_cnt0", 8'd3, 8'h00);

      // single port, 10-beat frame
      reg_write(8'd0, 8'h01);
      log_q.delete();
      c0 = cyc;
      load(0, 10, 1, 16'h0A00);
      wait_beats(10, 100);
      rd_check("t1_idle_after_last", 8'd2, 8'h00);
      check("t1_latency", log_q[0].cyc - c0, 1);
      for (int i = 0; i < 10; i++) begin
         check("t1_port", log_q[i].port, 0);
         check("t1_data", log_q[i].data, 16'h0A00 + 16'(i));
         check("t1_last", log_q[i].last, i == 9);
      end
      rd_check("t1_cnt0", 8'd3, 8'h01);

      // round robin, all four ports requesting
      do_reset(2);
      log_q.delete();
      load(0, 3, 2, 16'h1000);
      load(1, 3, 1, 16'h2000);
      load(2, 3, 1, 16'h3000);
      load(3, 3, 1, 16'h4000);
      wait_beats(15, 200);
      for (int i = 0; i < 15; i++) begin
         check("rr_port", log_q[i].port, ord[i/3]);
         check("rr_last", log_q[i].last, (i % 3) == 2);
      end
      check("rr_gap0_spacing", log_q[3].cyc - log_q[2].cyc, 2);
      rd_check("rr_cnt0", 8'd3, 8'h02);
      rd_check("rr_cnt1", 8'd4, 8'h01);
      rd_check("rr_cnt2", 8'd5, 8'h01);
      rd_check("rr_cnt3", 8'd6, 8'h01);

      // inter-frame gap of 5; rewriting gap during GAP must not disturb the running count
      reg_write(8'd1, 8'd5);
      log_q.delete();
      valid_cycles = 0;
      load(2, 3, 2, 16'h3100);
      wait_beats(3, 50);
      reg_write(8'd1, 8'd1);
      wait_beats(6, 50);
      check("gap5_spacing", log_q[3].cyc - log_q[2].cyc, 7);
      check("gap5_valid_cycles", valid_cycles, 6);
      rd_check("gap_reg", 8'd1, 8'h01);
      log_q.delete();
      load(2, 2, 2, 16'h3300);
      wait_beats(4, 50);
      check("gap1_spacing", log_q[2].cyc - log_q[1].cyc, 3);
      reg_write(8'd1, 8'd0);

      // backpressure toggling 1,0,1,0 on port 1
      log_q.delete();
      exp_port = 1;
      load(1, 4, 1, 16'h2100);
      for (int k = 0; k < 40 && log_q.size() < 4; k++) begin
         out_tready = (k % 2 == 0);
         step();
      end
      exp_port = -1;
      out_tready = 1'b1;
      check("bp_beats", log_q.size(), 4);
      for (int i = 0; i < 4; i++) begin
         check("bp_data", log_q[i].data, 16'h2100 + 16'(i));
         check("bp_last", log_q[i].last, i == 3);
      end
      rd_check("bp_cnt1", 8'd4, 8'h02);

      // mask cleared mid-frame: frame completes, no further grant
      reg_write(8'd0, 8'h02);
      log_q.delete();
      load(1, 4, 2, 16'h2200);
      wait_beats(1, 20);
      reg_write(8'd0, 8'h00);
      wait_beats(4, 20);
      repeat (20) step();
      check("mask_no_regrant", log_q.size(), 4);
      check("mask_last", log_q[3].last, 1'b1);
      rd_check("mask_cnt1", 8'd4, 8'h03);
      clear_srcs();

      // counter wrap on port 3, read racing an increment
      do_reset(2);
      log_q.delete();
      load(3, 1, 255, 16'h4000);
      wait_beats(255, 1000);
      rd_check("wrap_cnt3_255", 8'd6, 8'hFF);
      load(3, 1, 1, 16'h5000);
      step();
      rd_check("wrap_read_pre_incr", 8'd6, 8'hFF);
      rd_check("wrap_cnt3_0", 8'd6, 8'h00);
      check("wrap_beats", log_q.size(), 256);

      // reset mid-frame
      load(3, 8, 1, 16'h6000);
      wait_beats(259, 20);
      do_reset(1);
      check("midrst_tvalid", out_tvalid, 1'b0);
      check("midrst_tready", in_tready, 4'h0);
      rd_check("midrst_status", 8'd2, 8'h03);
      rd_check("midrst_mask", 8'd0, 8'h0F);

      // read-only / unmapped writes ignored, unmapped reads zero
      reg_write(8'd2, 8'hFF);
      reg_write(8'd6, 8'h55);
      reg_write(8'd0, 8'hF5);
      rd_check("ro_status", 8'd2, 8'h03);
      rd_check("ro_cnt3", 8'd6, 8'h00);
      rd_check("unmapped_7", 8'd7, 8'h00);
      rd_check("unmapped_200", 8'd200, 8'h00);
      rd_check("mask_upper_zero", 8'd0, 8'h05);
      step();
      check("rd_idle_zero", readdata, 8'h00);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
